// File: rtl/scan_chain_ctrl.sv
// Tester-side scan controller: loads a pattern through SE/SI, runs one capture
// cycle, unloads the response from SO and compares it against an expected vector.
//
// state     | meaning
// IDLE      | waiting for start, se=0
// SHIFT_IN  | CHAIN_LEN cycles, se=1, pattern MSB first on si
// CAPTURE   | one functional cycle, se=0
// SHIFT_OUT | CHAIN_LEN cycles, se=1, si=0, so sampled at each closing edge
// DONE      | one cycle, done=1, result published
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CLK,
    input  logic                 R,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic [CHAIN_LEN-1:0] expect_in,
    input  logic                 so,
    output logic                 se,
    output logic                 si,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] captured_out,
    output logic                 mismatch
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic [CHAIN_LEN-1:0] resp_q, resp_d;
    logic [CHAIN_LEN-1:0] cap_q, cap_d;
    logic                 mm_q, mm_d;
    logic                 se_q, se_d;
    logic                 si_q, si_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        exp_d   = exp_q;
        resp_d  = resp_q;
        cap_d   = cap_q;
        mm_d    = mm_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = pattern_in;
                    exp_d   = expect_in;
                    cnt_d   = '0;
                    state_d = SHIFT_IN;
                end
            end
            SHIFT_IN: begin
                // pattern register shifts so that its MSB is always the next si bit
                pat_d = {pat_q[CHAIN_LEN-2:0], 1'b0};
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                state_d = SHIFT_OUT;
            end
            SHIFT_OUT: begin
                resp_d = {resp_q[CHAIN_LEN-2:0], so};
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    cap_d   = resp_d;
                    mm_d    = (resp_d != exp_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // outputs are decoded from the next state so they are flop outputs
        se_d   = (state_d == SHIFT_IN) || (state_d == SHIFT_OUT);
        si_d   = (state_d == SHIFT_IN) && pat_d[CHAIN_LEN-1];
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (R) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            exp_q   <= '0;
            resp_q  <= '0;
            cap_q   <= '0;
            mm_q    <= 1'b0;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            exp_q   <= exp_d;
            resp_q  <= resp_d;
            cap_q   <= cap_d;
            mm_q    <= mm_d;
            se_q    <= se_d;
            si_q    <= si_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign se           = se_q;
    assign si           = si_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign captured_out = cap_q;
    assign mismatch     = mm_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: a 4-flop scan chain model with fixed functional
// inputs, directed runs, and a queue of expected results checked at done.
module tb_scan_chain_ctrl;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] cap;
        logic         mm;
    } sb_t;

    logic         CLK = 1'b0;
    logic         R = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] pattern_in = '0;
    logic [N-1:0] expect_in = '0;
    logic         so;
    logic         se, si, busy, done, mismatch;
    logic [N-1:0] captured_out;

    logic [N-1:0] chain_q = '0;
    logic [N-1:0] f_vec = 4'b1010;
    logic         chain_hold = 1'b0;

    sb_t          sb[$];
    logic [N-1:0] prev_cap = '0;
    logic         prev_mm = 1'b0;
    int           vectors = 0;
    int           errs = 0;

    scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
        .CLK(CLK), .R(R), .start(start), .pattern_in(pattern_in),
        .expect_in(expect_in), .so(so), .se(se), .si(si), .busy(busy),
        .done(done), .captured_out(captured_out), .mismatch(mismatch)
    );

    always #5 CLK = ~CLK;

    // scan chain: stage 0 nearest SI, SO from the last stage
    always @(posedge CLK) begin
        if (se) chain_q <= {chain_q[N-2:0], si};
        else if (!chain_hold) chain_q <= f_vec;
    end
    assign so = chain_q[N-1];

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_se"}, N'(se), '0);
        chk({tag, "_si"}, N'(si), '0);
        chk({tag, "_busy"}, N'(busy), '0);
        chk({tag, "_done"}, N'(done), '0);
        chk({tag, "_cap"}, captured_out, prev_cap);
        chk({tag, "_mm"}, N'(mismatch), N'(prev_mm));
    endtask

    // Full run starting from IDLE at a negedge; ends in cycle 11 (IDLE again).
    task automatic do_run(input string tag, input logic [N-1:0] pat, input logic [N-1:0] exp,
                          input bit hold, input bit extra_start);
        sb_t e, got;
        logic se_e, si_e, busy_e, done_e;
        chain_hold = hold;
        pattern_in = pat;
        expect_in  = exp;
        start      = 1'b1;
        e.cap = hold ? pat : f_vec;
        e.mm  = (e.cap != exp);
        sb.push_back(e);
        tick();
        pattern_in = ~pat;
        expect_in  = ~exp;
        for (int c = 1; c <= 11; c++) begin
            start  = 1'b0;
            se_e   = ((c >= 1) && (c <= 4)) || ((c >= 6) && (c <= 9));
            si_e   = (c <= 4) ? pat[4-c] : 1'b0;
            busy_e = (c <= 10);
            done_e = (c == 10);
            chk($sformatf("%s_c%0d_se", tag, c), N'(se), N'(se_e));
            chk($sformatf("%s_c%0d_si", tag, c), N'(si), N'(si_e));
            chk($sformatf("%s_c%0d_busy", tag, c), N'(busy), N'(busy_e));
            chk($sformatf("%s_c%0d_done", tag, c), N'(done), N'(done_e));
            if (c == 5) chk({tag, "_chain_after_load"}, chain_q, pat);
            if (c < 10) begin
                chk($sformatf("%s_c%0d_held_cap", tag, c), captured_out, prev_cap);
                chk($sformatf("%s_c%0d_held_mm", tag, c), N'(mismatch), N'(prev_mm));
            end
            if (c == 10) begin
                if (sb.size() == 0) begin
                    chk({tag, "_sb_empty"}, '1, '0);
                end else begin
                    got = sb.pop_front();
                    chk({tag, "_cap"}, captured_out, got.cap);
                    chk({tag, "_mm"}, N'(mismatch), N'(got.mm));
                    prev_cap = got.cap;
                    prev_mm  = got.mm;
                end
            end
            if (extra_start && ((c == 3) || (c == 10))) begin
                pattern_in = 4'b1111;
                start      = 1'b1;
            end
            if (c < 11) tick();
        end
        start      = 1'b0;
        chain_hold = 1'b0;
    endtask

    initial begin
        R = 1'b1;
        tick();
        tick();
        check_idle("reset");
        R = 1'b0;
        tick();
        check_idle("idle");

        f_vec = 4'b1010;
        do_run("match", 4'b0110, 4'b1010, 1'b0, 1'b0);
        do_run("miss", 4'b0110, 4'b1011, 1'b0, 1'b0);
        do_run("hold", 4'b1001, 4'b1001, 1'b1, 1'b0);
        do_run("restart", 4'b0011, 4'b1010, 1'b0, 1'b1);
        tick();
        check_idle("after_restart");

        // abort during SHIFT_IN cycle 2
        pattern_in = 4'b1100;
        expect_in  = 4'b0000;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        R = 1'b1;
        tick();
        R = 1'b0;
        sb.delete();
        prev_cap = '0;
        prev_mm  = 1'b0;
        check_idle("abort");
        tick();
        check_idle("abort_idle");
        do_run("fresh", 4'b0101, 4'b1010, 1'b0, 1'b0);

        // back-to-back: second start in the first IDLE cycle after DONE
        do_run("b2b_1", 4'b1110, 4'b0101, 1'b0, 1'b0);
        f_vec = 4'b0101;
        do_run("b2b_2", 4'b0001, 4'b0101, 1'b0, 1'b0);
        tick();
        check_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
